// File: rtl/msg_tx_arbiter_pkg.sv
// msg_tx_arbiter_pkg: shared state encoding and widths for the message transmit arbiter
package msg_tx_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;
  localparam int LEN_W = 8;
  localparam int DATA_W = 16;
  localparam int MAX_CH = 8;
  localparam int ID_W = $clog2(MAX_CH);
endpackage

// File: rtl/msg_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first requester after last, wrapping modulo N_CH
module rr_pick
  import msg_tx_arbiter_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] grant
);
  always_comb begin
    any = |req;
    grant = last;
    for (int k = N_CH; k >= 1; k--)
      grant = |(req & (N_CH'(1) << ((int'(last) + k) % N_CH))) ? ID_W'((int'(last) + k) % N_CH) : grant;
  end
endmodule

// File: rtl/msg_tx_arbiter.sv
// msg_tx_arbiter: drains whole messages from per-channel length/data FIFOs onto one 16-bit link, round-robin per message
module msg_tx_arbiter
  import msg_tx_arbiter_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   RST,
  input  logic                   RX_CLK,
  input  logic [N_CH-1:0]        LEN_EMPTY,
  input  logic [LEN_W*N_CH-1:0]  LEN_Q,
  output logic [N_CH-1:0]        LEN_RDREQ,
  input  logic [N_CH-1:0]        DATA_EMPTY,
  input  logic [DATA_W*N_CH-1:0] DATA_Q,
  output logic [N_CH-1:0]        DATA_RDREQ,
  input  logic                   TX_READY,
  output logic [DATA_W-1:0]      TX_DATA,
  output logic                   TX_ENA,
  output logic [2:0]             GRANT_ID,
  output logic                   BUSY,
  output logic                   ZERO_LEN_ERR,
  output logic [15:0]            MSG_COUNT
);
  state_t state, nxt;
  logic [ID_W-1:0] grant_id, pick;
  logic any, grab, xfer, done;
  logic [LEN_W-1:0] remaining, len_sel;
  logic [DATA_W-1:0] last_data, cur_data;
  logic [N_CH-1:0] sel;
  logic [3:0] gap_cnt;
  logic [15:0] msg_count;
  rr_pick #(.N_CH(N_CH)) u_pick (
    .req  (~LEN_EMPTY),
    .last (grant_id),
    .any  (any),
    .grant(pick)
  );
  always_comb begin
    len_sel = LEN_W'(LEN_Q >> (LEN_W * pick));
    cur_data = DATA_W'(DATA_Q >> (DATA_W * grant_id));
    sel = N_CH'(1) << grant_id;
    grab = RST && state == ST_IDLE && any;
    xfer = RST && state == ST_SEND && TX_READY && |(sel & ~DATA_EMPTY);
    done = xfer && remaining == LEN_W'(1);
    nxt = state == ST_IDLE ? ((grab && len_sel != '0) ? ST_SEND : ST_IDLE) :
          state == ST_SEND ? (done ? (GAP_CYCLES > 0 ? ST_GAP : ST_IDLE) : ST_SEND) :
          state == ST_GAP  ? (int'(gap_cnt) == GAP_CYCLES - 1 ? ST_IDLE : ST_GAP) : ST_IDLE;
    LEN_RDREQ = grab ? N_CH'(1) << pick : '0;
    DATA_RDREQ = xfer ? sel : '0;
    TX_ENA = xfer;
    TX_DATA = xfer ? cur_data : last_data;
    ZERO_LEN_ERR = grab && len_sel == '0;
  end
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      grant_id <= ID_W'(N_CH - 1);
      remaining <= '0;
      last_data <= '0;
      gap_cnt <= '0;
      msg_count <= '0;
    end else begin
      state <= nxt;
      gap_cnt <= state == ST_GAP ? gap_cnt + 4'd1 : 4'd0;
      if (grab) begin
        grant_id <= pick;
        remaining <= len_sel;
      end
      if (xfer) begin
        remaining <= remaining - LEN_W'(1);
        last_data <= cur_data;
      end
      if (done) msg_count <= msg_count + 16'd1;
    end
  end
  assign GRANT_ID = 3'(grant_id);
  assign BUSY = state != ST_IDLE;
  assign MSG_COUNT = msg_count;
endmodule

// File: tb/tb_msg_tx_arbiter.sv
// tb_msg_tx_arbiter: directed stimulus with bench-side FIFOs, a message-level reference model and literal spot checks
module tb_msg_tx_arbiter;
  localparam int N = 4;
  localparam int GAP = 1;
  logic RX_CLK = 1'b0;
  logic RST = 1'b1;
  logic tx_ready = 1'b1;
  logic [N-1:0] len_empty = '1;
  logic [N-1:0] data_empty = '1;
  logic [8*N-1:0] len_q = '0;
  logic [16*N-1:0] data_q = '0;
  logic [N-1:0] LEN_RDREQ, DATA_RDREQ;
  logic [15:0] TX_DATA, MSG_COUNT;
  logic TX_ENA, BUSY, ZERO_LEN_ERR;
  logic [2:0] GRANT_ID;
  logic [7:0] lq [N][$];
  logic [15:0] dq [N][$];
  logic [N-1:0] hold = '0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_last = N - 1;
  int m_left = 0;
  int m_gap = 0;
  logic [15:0] m_cnt = '0;
  logic [15:0] m_txd = '0;
  logic [N-1:0] e_lrd, e_drd;
  logic e_ena, e_busy, e_zerr;
  logic [15:0] e_txd, e_cnt;
  logic [2:0] e_gid;
  int g, pop_len, pop_data;
  int grant_log[$], grant_cyc[$], tx_cyc[$], zerr_cyc[$];
  logic [15:0] tx_log[$];
  int stall_cnt = 0;
  int drd_cnt[N];
  always #5 RX_CLK = ~RX_CLK;
  msg_tx_arbiter #(.N_CH(N), .GAP_CYCLES(GAP)) dut (
    .RST(RST), .RX_CLK(RX_CLK),
    .LEN_EMPTY(len_empty), .LEN_Q(len_q), .LEN_RDREQ(LEN_RDREQ),
    .DATA_EMPTY(data_empty), .DATA_Q(data_q), .DATA_RDREQ(DATA_RDREQ),
    .TX_READY(tx_ready), .TX_DATA(TX_DATA), .TX_ENA(TX_ENA),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .ZERO_LEN_ERR(ZERO_LEN_ERR), .MSG_COUNT(MSG_COUNT)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge RX_CLK);
    #2;
  endtask
  function automatic logic [15:0] tx_at(input int i);
    return i < tx_log.size() ? tx_log[i] : 16'hFFFF;
  endfunction
  function automatic int grant_at(input int i);
    return i < grant_log.size() ? grant_log[i] : -1;
  endfunction
  function automatic int gcyc_at(input int i);
    return i < grant_cyc.size() ? grant_cyc[i] : -1;
  endfunction
  function automatic int tcyc_at(input int i);
    return i < tx_cyc.size() ? tx_cyc[i] : -1;
  endfunction
  function automatic bit all_len_empty;
    for (int c = 0; c < N; c++) if (lq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic clear_logs;
    grant_log.delete(); grant_cyc.delete(); tx_cyc.delete(); zerr_cyc.delete(); tx_log.delete();
    stall_cnt = 0;
    for (int c = 0; c < N; c++) drd_cnt[c] = 0;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(all_len_empty() && m_left == 0 && m_gap == 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", 32'(n < budget), 32'd1);
  endtask
  task automatic wait_grants(input int k, input int budget);
    int n = 0;
    while (grant_log.size() < k && n < budget) begin
      tick();
      n++;
    end
    chk("grant_within_budget", 32'(n < budget), 32'd1);
  endtask
  task automatic wait_words(input int k, input int budget);
    int n = 0;
    while (tx_log.size() < k && n < budget) begin
      tick();
      n++;
    end
    chk("words_within_budget", 32'(n < budget), 32'd1);
  endtask
  always @(negedge RX_CLK) begin
    for (int c = 0; c < N; c++) begin
      len_empty[c] = lq[c].size() == 0;
      len_q[8*c +: 8] = lq[c].size() == 0 ? 8'h00 : lq[c][0];
      data_empty[c] = dq[c].size() == 0 || hold[c];
      data_q[16*c +: 16] = dq[c].size() == 0 ? 16'h0000 : dq[c][0];
    end
    #1;
    cyc++;
    e_lrd = '0; e_drd = '0; e_ena = 1'b0; e_zerr = 1'b0;
    e_busy = m_left > 0 || m_gap > 0;
    e_gid = 3'(m_last);
    e_cnt = m_cnt;
    e_txd = m_txd;
    pop_len = -1; pop_data = -1;
    if (!RST) begin
      m_last = N - 1; m_left = 0; m_gap = 0; m_cnt = '0; m_txd = '0;
      e_busy = 1'b0; e_gid = 3'(N - 1); e_cnt = '0; e_txd = '0;
    end else if (m_left > 0) begin
      if (tx_ready && dq[m_last].size() != 0 && !hold[m_last]) begin
        e_ena = 1'b1;
        e_drd[m_last] = 1'b1;
        e_txd = dq[m_last][0];
        m_txd = e_txd;
        pop_data = m_last;
        m_left--;
        if (m_left == 0) begin
          m_cnt++;
          m_gap = GAP;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      g = -1;
      for (int k = 1; k <= N; k++) if (g < 0 && lq[(m_last + k) % N].size() != 0) g = (m_last + k) % N;
      if (g >= 0) begin
        e_lrd[g] = 1'b1;
        pop_len = g;
        m_last = g;
        if (lq[g][0] == 8'd0) e_zerr = 1'b1;
        else m_left = int'(lq[g][0]);
      end
    end
    chk("LEN_RDREQ", 32'(LEN_RDREQ), 32'(e_lrd));
    chk("DATA_RDREQ", 32'(DATA_RDREQ), 32'(e_drd));
    chk("TX_ENA", 32'(TX_ENA), 32'(e_ena));
    chk("TX_DATA", 32'(TX_DATA), 32'(e_txd));
    chk("GRANT_ID", 32'(GRANT_ID), 32'(e_gid));
    chk("BUSY", 32'(BUSY), 32'(e_busy));
    chk("ZERO_LEN_ERR", 32'(ZERO_LEN_ERR), 32'(e_zerr));
    chk("MSG_COUNT", 32'(MSG_COUNT), 32'(e_cnt));
    for (int c = 0; c < N; c++) begin
      if (LEN_RDREQ[c]) begin
        grant_log.push_back(c);
        grant_cyc.push_back(cyc);
      end
      if (DATA_RDREQ[c]) drd_cnt[c]++;
    end
    if (TX_ENA) begin
      tx_log.push_back(TX_DATA);
      tx_cyc.push_back(cyc);
    end
    if (ZERO_LEN_ERR) zerr_cyc.push_back(cyc);
    if (BUSY && !TX_ENA) stall_cnt++;
    if (pop_len >= 0) void'(lq[pop_len].pop_front());
    if (pop_data >= 0) void'(dq[pop_data].pop_front());
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end
  initial begin
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    chk("rst_grant_id", 32'(GRANT_ID), 32'd3);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_msg_count", 32'(MSG_COUNT), 32'd0);
    chk("rst_tx_data", 32'(TX_DATA), 32'd0);
    chk("rst_tx_ena", 32'(TX_ENA), 32'd0);
    repeat (2) tick();
    RST = 1'b1;
    clear_logs();
    lq[0].push_back(8'd3);
    dq[0].push_back(16'h00A1); dq[0].push_back(16'h00A2); dq[0].push_back(16'h00A3);
    wait_idle(50);
    chk("t1_grant", 32'(grant_at(0)), 32'd0);
    chk("t1_nwords", 32'(tx_log.size()), 32'd3);
    chk("t1_w0", 32'(tx_at(0)), 32'h00A1);
    chk("t1_w1", 32'(tx_at(1)), 32'h00A2);
    chk("t1_w2", 32'(tx_at(2)), 32'h00A3);
    chk("t1_first_word_latency", 32'(tcyc_at(0) - gcyc_at(0)), 32'd1);
    chk("t1_last_word_latency", 32'(tcyc_at(2) - gcyc_at(0)), 32'd3);
    chk("t1_gap_cycles", 32'(stall_cnt), 32'd1);
    chk("t1_msg_count", 32'(MSG_COUNT), 32'd1);
    RST = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    clear_logs();
    for (int c = 0; c < N; c++)
      for (int r = 0; r < 2; r++) begin
        lq[c].push_back(8'd2);
        for (int w = 0; w < 2; w++) dq[c].push_back(16'(16'hC000 + c * 256 + r * 16 + w));
      end
    wait_idle(100);
    for (int i = 0; i < 8; i++) chk("t2_grant_order", 32'(grant_at(i)), 32'(i % 4));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++)
        for (int w = 0; w < 2; w++)
          chk("t2_word", 32'(tx_at(r * 8 + c * 2 + w)), 32'(16'hC000 + c * 256 + r * 16 + w));
    chk("t2_msg_count", 32'(MSG_COUNT), 32'd8);
    clear_logs();
    lq[2].push_back(8'd4);
    dq[2].push_back(16'h0031); dq[2].push_back(16'h0032); dq[2].push_back(16'h0033); dq[2].push_back(16'h0034);
    wait_grants(1, 20);
    tick();
    tx_ready = 1'b0;
    repeat (2) tick();
    tx_ready = 1'b1;
    wait_idle(50);
    chk("t3_grant", 32'(grant_at(0)), 32'd2);
    chk("t3_nwords", 32'(tx_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_word", 32'(tx_at(i)), 32'(16'h0031 + i));
    chk("t3_data_pops", 32'(drd_cnt[2]), 32'd4);
    chk("t3_idle_busy_cycles", 32'(stall_cnt), 32'd3);
    chk("t3_msg_count", 32'(MSG_COUNT), 32'd9);
    clear_logs();
    hold[1] = 1'b1;
    lq[1].push_back(8'd3);
    dq[1].push_back(16'h0041); dq[1].push_back(16'h0042); dq[1].push_back(16'h0043);
    wait_grants(1, 20);
    lq[3].push_back(8'd1);
    dq[3].push_back(16'h0049);
    repeat (5) tick();
    chk("t4_lag_busy", 32'(BUSY), 32'd1);
    chk("t4_lag_grant_id", 32'(GRANT_ID), 32'd1);
    chk("t4_lag_no_words", 32'(tx_log.size()), 32'd0);
    hold[1] = 1'b0;
    wait_idle(50);
    chk("t4_grant0", 32'(grant_at(0)), 32'd1);
    chk("t4_grant1", 32'(grant_at(1)), 32'd3);
    chk("t4_ngrants", 32'(grant_log.size()), 32'd2);
    for (int i = 0; i < 3; i++) chk("t4_word", 32'(tx_at(i)), 32'(16'h0041 + i));
    chk("t4_word_ch3", 32'(tx_at(3)), 32'h0049);
    chk("t4_idle_busy_cycles", 32'(stall_cnt), 32'd7);
    chk("t4_msg_count", 32'(MSG_COUNT), 32'd11);
    clear_logs();
    lq[2].push_back(8'd0);
    dq[2].push_back(16'hDEAD);
    lq[3].push_back(8'd1);
    dq[3].push_back(16'h0055);
    wait_idle(50);
    chk("t5_grant0", 32'(grant_at(0)), 32'd2);
    chk("t5_grant1", 32'(grant_at(1)), 32'd3);
    chk("t5_zerr_count", 32'(zerr_cyc.size()), 32'd1);
    chk("t5_zerr_with_pop", 32'(zerr_cyc.size() > 0 ? zerr_cyc[0] : -1), 32'(gcyc_at(0)));
    chk("t5_next_grant_delay", 32'(gcyc_at(1) - gcyc_at(0)), 32'd1);
    chk("t5_ch2_no_data_pop", 32'(drd_cnt[2]), 32'd0);
    chk("t5_word", 32'(tx_at(0)), 32'h0055);
    chk("t5_msg_count", 32'(MSG_COUNT), 32'd12);
    clear_logs();
    lq[0].push_back(8'd5);
    for (int i = 0; i < 5; i++) dq[0].push_back(16'(16'h0070 + i));
    wait_words(2, 20);
    RST = 1'b0;
    #1;
    chk("t6_rst_tx_ena", 32'(TX_ENA), 32'd0);
    chk("t6_rst_tx_data", 32'(TX_DATA), 32'd0);
    chk("t6_rst_len_rdreq", 32'(LEN_RDREQ), 32'd0);
    chk("t6_rst_data_rdreq", 32'(DATA_RDREQ), 32'd0);
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    chk("t6_rst_grant_id", 32'(GRANT_ID), 32'd3);
    chk("t6_rst_msg_count", 32'(MSG_COUNT), 32'd0);
    chk("t6_rst_zerr", 32'(ZERO_LEN_ERR), 32'd0);
    for (int c = 0; c < N; c++) begin
      lq[c].delete();
      dq[c].delete();
    end
    hold = '0;
    clear_logs();
    lq[1].push_back(8'd1); dq[1].push_back(16'h0061);
    lq[0].push_back(8'd1); dq[0].push_back(16'h0060);
    repeat (2) tick();
    RST = 1'b1;
    wait_idle(50);
    chk("t6_first_grant", 32'(grant_at(0)), 32'd0);
    chk("t6_second_grant", 32'(grant_at(1)), 32'd1);
    chk("t6_w0", 32'(tx_at(0)), 32'h0060);
    chk("t6_w1", 32'(tx_at(1)), 32'h0061);
    chk("t6_msg_count", 32'(MSG_COUNT), 32'd2);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
